demux8_stream: RTL and testbench



---
 rtl/demux8_pkg.sv | 8 +
 rtl/demux8_slot.sv | 39 +++
 rtl/demux8_stream.sv | 36 +++
 tb/tb_demux8_stream.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/demux8_pkg.sv
// demux8_pkg: shared constants and types for the eight-way stream demultiplexer
package demux8_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 8;
  typedef logic [SEL_W-1:0] sel_t;
  typedef enum logic {EMPTY, FULL} slot_state_t;
endpackage

// File: rtl/demux8_slot.sv
// demux8_slot: one-entry holding slot with optional saturating delivery counter (DEMUX8_STREAM_COUNT_EN)
module demux8_slot
  import demux8_pkg::*;
#(
  parameter int N = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [N-1:0]     data_in,
  output logic             valid,
  output logic [N-1:0]     data_out,
  output logic [CNT_W-1:0] count
);
  slot_state_t state;
  assign valid = state == FULL;
  // load wins over drain so a simultaneous accept and drain reloads without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      data_out <= '0;
    end else if (load) begin
      state    <= FULL;
      data_out <= data_in;
    end else if (drain) begin
      state    <= EMPTY;
    end
  end
`ifdef DEMUX8_STREAM_COUNT_EN
  // delivery counter sticks at its maximum instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (drain && count != '1) count <= count + 1'b1;
  end
`else
  assign count = '0;
`endif
endmodule

// File: rtl/demux8_stream.sv
// demux8_stream: routes one valid/ready stream to eight buffered channels by select; counters via DEMUX8_STREAM_COUNT_EN
module demux8_stream
  import demux8_pkg::*;
#(
  parameter int N = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            in_data,
  input  sel_t                    in_select,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*N-1:0]     out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*CNT_W-1:0] out_count
);
  logic accept;
  logic [NUM_CH-1:0] load;
  assign in_ready = !out_valid[in_select] || out_ready[in_select];
  assign accept   = in_valid && in_ready;
  genvar k;
  for (k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = accept && in_select == sel_t'(k);
    demux8_slot #(.N(N)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .drain    (out_valid[k] && out_ready[k]),
      .data_in  (in_data),
      .valid    (out_valid[k]),
      .data_out (out_data[k*N +: N]),
      .count    (out_count[k*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_demux8_stream.sv
// tb_demux8_stream: randomized and directed checks of demux8_stream against a slot-array model
module tb_demux8_stream;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  in_data = '0;
  logic [2:0]  in_select = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [63:0] out_count;
  int total = 0;
  int passed = 0;
  logic       mv [8];
  logic [7:0] md [8];
  int         mc [8];
  logic       last_acc;

  demux8_stream #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_select(in_select),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mv[k] = 0;
      md[k] = '0;
      mc[k] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0]  ev;
    logic [63:0] ed;
    logic [63:0] ec;
    for (int k = 0; k < 8; k++) begin
      ev[k] = mv[k];
      ed[k*8 +: 8] = md[k];
`ifdef DEMUX8_STREAM_COUNT_EN
      ec[k*8 +: 8] = 8'(mc[k]);
`else
      ec[k*8 +: 8] = 8'd0;
`endif
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".out_data"}, out_data, ed);
    chk({tag, ".out_count"}, out_count, ec);
  endtask

  // drive one cycle at posedge+1, check in_ready, advance the model, check outputs at posedge+1
  task automatic step(input string tag, input logic v, input logic [2:0] s,
                      input logic [7:0] d, input logic [7:0] r);
    logic exp_rdy;
    in_valid = v; in_select = s; in_data = d; out_ready = r;
    #1;
    exp_rdy = !mv[s] || r[s];
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    last_acc = v && exp_rdy;
    for (int k = 0; k < 8; k++)
      if (mv[k] && r[k]) begin
        mv[k] = 0;
        if (mc[k] < 255) mc[k]++;
      end
    if (last_acc) begin
      mv[s] = 1;
      md[s] = d;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic       v;
    logic [2:0] s;
    logic [7:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("in_reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    compare_all("reset_release");
    for (int i = 0; i < 8; i++) begin
      in_select = 3'(i);
      #1;
      chk("idle_in_ready", 64'(in_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    step("send_a5", 1, 3'd3, 8'hA5, 8'h00);
    chk("slot3_a5", out_data[31:24], 64'hA5);
    chk("valid_only3", 64'(out_valid), 64'h08);
    step("blocked", 1, 3'd3, 8'h77, 8'h00);
    chk("blocked_ready", 64'(last_acc), 64'd0);
    step("idle1", 0, 3'd3, 8'h77, 8'h00);
    step("reload_5a", 1, 3'd3, 8'h5A, 8'h08);
    chk("reload_data", out_data[31:24], 64'h5A);
    chk("reload_valid", 64'(out_valid[3]), 64'd1);
    step("refill_a5", 0, 3'd0, 8'h00, 8'h08);
    step("refill_a5b", 1, 3'd3, 8'hA5, 8'h00);
    step("side_11", 1, 3'd0, 8'h11, 8'h00);
    step("side_22", 1, 3'd7, 8'h22, 8'h00);
    chk("stalled_keep", out_data[31:24], 64'hA5);
    chk("side_valid", 64'(out_valid), 64'h89);
    for (int i = 0; i < 16; i++) begin
      step("stream", 1, 3'd5, 8'(i), 8'h20);
      chk("stream_data", out_data[47:40], 64'(i));
    end
    step("stream_end", 0, 3'd5, 8'h00, 8'h20);
    chk("stream_drained", 64'(out_valid[5]), 64'd0);
    rst_n = 0;
    #1;
    chk("async_reset", 64'(out_valid), 64'h00);
    chk("async_reset_data", out_data, 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all("held_reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 301; i++) step("sat", 1, 3'd2, 8'(i), 8'h04);
    step("sat_end", 0, 3'd2, 8'h00, 8'h04);
`ifdef DEMUX8_STREAM_COUNT_EN
    chk("sat_count", out_count, 64'h0000_0000_00FF_0000);
`else
    chk("no_count", out_count, 64'h0);
`endif
    last_acc = 1;
    v = 0; s = '0; d = '0;
    for (int i = 0; i < 500; i++) begin
      if (!(v && !last_acc)) begin
        v = 1'($urandom);
        s = 3'($urandom);
        d = 8'($urandom);
      end
      step("rand", v, s, d, 8'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
